// File: rtl/systolic_2x2.sv
// rtl/systolic_2x2.sv - weight-stationary 2x2 systolic array, one activation row in and one output row out per cycle
module systolic_2x2 #(
    parameter int                      A_W = 4,
    parameter int                      C_W = 8,
    parameter logic signed [A_W-1:0]   W00 = A_W'(1),
    parameter logic signed [A_W-1:0]   W01 = A_W'(2),
    parameter logic signed [A_W-1:0]   W10 = A_W'(3),
    parameter logic signed [A_W-1:0]   W11 = A_W'(4)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [A_W-1:0]  a_row0_in,
    input  logic signed [A_W-1:0]  a_row1_in,
    output logic signed [C_W-1:0]  c_col0_out,
    output logic signed [C_W-1:0]  c_col1_out
);

    // Weights widened once so every product is formed at partial-sum width
    // and wraps modulo 2^C_W like the accumulations do.
    localparam logic signed [C_W-1:0] W00_X = C_W'(W00);
    localparam logic signed [C_W-1:0] W01_X = C_W'(W01);
    localparam logic signed [C_W-1:0] W10_X = C_W'(W10);
    localparam logic signed [C_W-1:0] W11_X = C_W'(W11);

    function automatic logic signed [C_W-1:0] sext(input logic signed [A_W-1:0] v);
        return C_W'(v);
    endfunction

    // Activation pipes: a0 forwarded PE00 -> PE01, a1 skewed one cycle
    // into PE10, then forwarded PE10 -> PE11.
    logic signed [A_W-1:0] a0_q, a0_d;
    logic signed [A_W-1:0] a1_skew_q, a1_skew_d;
    logic signed [A_W-1:0] a1_fwd_q, a1_fwd_d;

    // Partial sums held by each PE, plus the col0 deskew stage.
    logic signed [C_W-1:0] pe00_q, pe00_d;
    logic signed [C_W-1:0] pe10_q, pe10_d;
    logic signed [C_W-1:0] pe01_q, pe01_d;
    logic signed [C_W-1:0] pe11_q, pe11_d;
    logic signed [C_W-1:0] deskew_q, deskew_d;

    // PE multiply-accumulate and forwarding network
    always_comb begin
        a0_d      = a_row0_in;
        a1_skew_d = a_row1_in;
        a1_fwd_d  = a1_skew_q;
        pe00_d    = sext(a_row0_in) * W00_X;
        pe10_d    = pe00_q + sext(a1_skew_q) * W10_X;
        pe01_d    = sext(a0_q) * W01_X;
        pe11_d    = pe01_q + sext(a1_fwd_q) * W11_X;
        deskew_d  = pe10_q;
    end

    // Pipeline registers, all cleared at once by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q      <= '0;
            a1_skew_q <= '0;
            a1_fwd_q  <= '0;
            pe00_q    <= '0;
            pe10_q    <= '0;
            pe01_q    <= '0;
            pe11_q    <= '0;
            deskew_q  <= '0;
        end else begin
            a0_q      <= a0_d;
            a1_skew_q <= a1_skew_d;
            a1_fwd_q  <= a1_fwd_d;
            pe00_q    <= pe00_d;
            pe10_q    <= pe10_d;
            pe01_q    <= pe01_d;
            pe11_q    <= pe11_d;
            deskew_q  <= deskew_d;
        end
    end

    // Both columns leave straight from registers, aligned to the same row.
    assign c_col0_out = deskew_q;
    assign c_col1_out = pe11_q;

endmodule

// File: tb/tb_systolic_2x2.sv
// tb/tb_systolic_2x2.sv - directed-vector self-checking bench for systolic_2x2
module tb_systolic_2x2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [3:0] a0, a1;
    logic signed [7:0] c0, c1;
    logic signed [3:0] wa0, wa1;
    logic signed [7:0] wc0, wc1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    systolic_2x2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_row0_in  (a0),
        .a_row1_in  (a1),
        .c_col0_out (c0),
        .c_col1_out (c1)
    );

    systolic_2x2 #(
        .W00 (-4'sd8),
        .W10 (-4'sd8)
    ) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_row0_in  (wa0),
        .a_row1_in  (wa1),
        .c_col0_out (wc0),
        .c_col1_out (wc1)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Ten-row stream and its hand-computed results, followed by flush zeros.
    int in0 [10] = '{1, 2, 0, 0, 1,  3, 1, 1, -1,  3};
    int in1 [10] = '{0, 1, 1, 1, 1, -1, 1, 1,  2, -2};
    int ex0 [14] = '{1, 5, 3, 3, 4, 0, 4, 4, 5, -3, 0, 0, 0, 0};
    int ex1 [14] = '{2, 8, 4, 4, 6, 2, 6, 6, 6, -2, 0, 0, 0, 0};

    initial begin
        rst_n = 1'b0;
        a0 = '0; a1 = '0;
        wa0 = -4'sd8; wa1 = -4'sd8;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_col0", c0, 0);
            check("rst_col1", c1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            a0 = (i < 10) ? 4'(in0[i]) : 4'sd0;
            a1 = (i < 10) ? 4'(in1[i]) : 4'sd0;
            @(posedge clk); #1;
            check($sformatf("stream_col0[%0d]", i), c0, (i >= 2) ? ex0[i-2] : 0);
            check($sformatf("stream_col1[%0d]", i), c1, (i >= 2) ? ex1[i-2] : 0);
        end

        a0 = 4'sd1; a1 = 4'sd1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_col0", c0, 4);
        check("pre_rst_col1", c1, 6);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_col0", c0, 0);
        check("async_rst_col1", c1, 0);
        @(posedge clk); #1;
        check("held_rst_col0", c0, 0);
        check("held_rst_col1", c1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a0 = 4'sd1; a1 = 4'sd1;
        @(posedge clk); #1;
        a0 = '0; a1 = '0;
        check("restart_e0_col0", c0, 0);
        check("restart_e0_col1", c1, 0);
        @(posedge clk); #1;
        check("restart_e1_col0", c0, 0);
        check("restart_e1_col1", c1, 0);
        @(posedge clk); #1;
        check("restart_e2_col0", c0, 4);
        check("restart_e2_col1", c1, 6);
        @(posedge clk); #1;
        check("restart_e3_col0", c0, 0);
        check("restart_e3_col1", c1, 0);

        check("wrap_col0", wc0, -128);
        check("wrap_col1", wc1, -48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
